// File: rtl/mole_timer.sv
// Mole event timer: random delay, one-hot mole, then hit / miss / wrong.
// Consumes the RNG word and the ms tick; all outputs registered.
module mole_timer #(
    parameter int DELAY_W    = 11,
    parameter int N_MOLES    = 4,
    parameter int UP_TIME_MS = 1000,
    parameter int UP_W       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               tick_ms,
    input  logic [DELAY_W-1:0] random_value,
    input  logic [N_MOLES-1:0] buttons,
    output logic [N_MOLES-1:0] mole_leds,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               wrong_pulse,
    output logic               busy
);

    localparam int IDX_W = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, UP} state_t;

    state_t             state, state_d;
    logic [DELAY_W-1:0] delay_cnt, delay_d;
    logic [UP_W-1:0]    up_cnt, up_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [N_MOLES-1:0] leds_d;
    logic               hit_d, miss_d, wrong_d;

    logic [DELAY_W-1:0] load_delay;
    logic [DELAY_W-1:0] rem;
    logic [IDX_W-1:0]   new_idx;
    logic               hit_now;
    logic               wait_last;
    logic               up_last;

    // Decoded helpers: zero delay treated as one, mole index from RNG word.
    always_comb begin
        load_delay = (random_value == '0) ? DELAY_W'(1) : random_value;
        rem        = random_value % DELAY_W'(N_MOLES);
        new_idx    = rem[IDX_W-1:0];
        hit_now    = buttons[idx];
        wait_last  = tick_ms && (delay_cnt <= DELAY_W'(1));
        up_last    = tick_ms && (up_cnt <= UP_W'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic; enable low wins over any pending event.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (enable) state_d = WAIT;
            WAIT: begin
                if (!enable)        state_d = IDLE;
                else if (wait_last) state_d = UP;
            end
            UP: begin
                if (!enable)                  state_d = IDLE;
                else if (hit_now || up_last)  state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for counters, mole index and the registered outputs.
    always_comb begin
        delay_d = delay_cnt;
        up_d    = up_cnt;
        idx_d   = idx;
        leds_d  = mole_leds;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        wrong_d = 1'b0;
        if (!enable) begin
            leds_d = '0;
        end else begin
            unique case (state)
                IDLE: delay_d = load_delay;
                WAIT: begin
                    if (wait_last) begin
                        up_d            = UP_W'(UP_TIME_MS);
                        idx_d           = new_idx;
                        leds_d          = '0;
                        leds_d[new_idx] = 1'b1;
                    end else if (tick_ms) begin
                        delay_d = delay_cnt - DELAY_W'(1);
                    end
                end
                UP: begin
                    if (hit_now) begin
                        hit_d   = 1'b1;
                        leds_d  = '0;
                        delay_d = load_delay;
                    end else begin
                        wrong_d = |buttons;
                        if (up_last) begin
                            miss_d  = 1'b1;
                            leds_d  = '0;
                            delay_d = load_delay;
                        end else if (tick_ms) begin
                            up_d = up_cnt - UP_W'(1);
                        end
                    end
                end
                default: leds_d = '0;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_cnt   <= '0;
            up_cnt      <= '0;
            idx         <= '0;
            mole_leds   <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            wrong_pulse <= 1'b0;
            busy        <= 1'b0;
        end else begin
            delay_cnt   <= delay_d;
            up_cnt      <= up_d;
            idx         <= idx_d;
            mole_leds   <= leds_d;
            hit_pulse   <= hit_d;
            miss_pulse  <= miss_d;
            wrong_pulse <= wrong_d;
            busy        <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_mole_timer.sv
// Testbench for mole_timer: directed scenarios then random traffic,
// checked against a tick-counting reference model.
module tb_mole_timer;

    localparam int DW  = 11;
    localparam int NM  = 4;
    localparam int UPT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          tick_ms;
    logic [DW-1:0] random_value;
    logic [NM-1:0] buttons;
    logic [NM-1:0] mole_leds;
    logic          hit_pulse, miss_pulse, wrong_pulse, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 waiting, 2 mole up.
    int m_mode, m_target, m_waited, m_idx, m_upticks;
    logic [NM-1:0] e_leds;
    logic e_hit, e_miss, e_wrong, e_busy;

    mole_timer #(
        .DELAY_W(DW), .N_MOLES(NM), .UP_TIME_MS(UPT), .UP_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick_ms(tick_ms),
        .random_value(random_value), .buttons(buttons),
        .mole_leds(mole_leds), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .wrong_pulse(wrong_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_target = 0; m_waited = 0; m_idx = 0; m_upticks = 0;
        e_leds = '0; e_hit = 0; e_miss = 0; e_wrong = 0; e_busy = 0;
    endtask

    task automatic model_step(input logic en, input logic tk,
                              input int rv, input logic [NM-1:0] bt);
        e_hit = 0; e_miss = 0; e_wrong = 0;
        if (!en) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_waited = 0; m_target = (rv == 0) ? 1 : rv;
        end else if (m_mode == 1) begin
            if (tk) begin
                m_waited++;
                if (m_waited == m_target) begin
                    m_mode = 2; m_idx = rv % NM; m_upticks = 0;
                end
            end
        end else begin
            if (bt[m_idx]) begin
                e_hit = 1;
                m_mode = 1; m_waited = 0; m_target = (rv == 0) ? 1 : rv;
            end else begin
                e_wrong = (bt != 0);
                if (tk) begin
                    m_upticks++;
                    if (m_upticks == UPT) begin
                        e_miss = 1;
                        m_mode = 1; m_waited = 0;
                        m_target = (rv == 0) ? 1 : rv;
                    end
                end
            end
        end
        e_leds = (m_mode == 2) ? NM'(1 << m_idx) : '0;
        e_busy = (m_mode != 0);
    endtask

    task automatic check();
        n_cmp++;
        assert (mole_leds === e_leds) else begin
            n_err++;
            $error("FAIL leds got %b exp %b", mole_leds, e_leds);
        end
        n_cmp++;
        assert (hit_pulse === e_hit) else begin
            n_err++;
            $error("FAIL hit got %b exp %b", hit_pulse, e_hit);
        end
        n_cmp++;
        assert (miss_pulse === e_miss) else begin
            n_err++;
            $error("FAIL miss got %b exp %b", miss_pulse, e_miss);
        end
        n_cmp++;
        assert (wrong_pulse === e_wrong) else begin
            n_err++;
            $error("FAIL wrong got %b exp %b", wrong_pulse, e_wrong);
        end
        n_cmp++;
        assert (busy === e_busy) else begin
            n_err++;
            $error("FAIL busy got %b exp %b", busy, e_busy);
        end
    endtask

    // Called at a falling edge: drive inputs, advance model, check next fall.
    task automatic cyc(input logic en, input logic tk,
                       input int rv, input logic [NM-1:0] bt);
        enable = en; tick_ms = tk; random_value = DW'(rv); buttons = bt;
        model_step(en, tk, rv, bt);
        @(negedge clk);
        check();
    endtask

    task automatic expect_bit(input string tag, input logic got,
                              input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 0; tick_ms = 0; random_value = '0; buttons = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check();
        rst_n = 1'b1;

        // Delay 5, tick every 4 clocks: mole at idx 1 on the 5th tick.
        for (int i = 0; i < 20; i++) cyc(1, (i % 4) == 3, 5, '0);
        expect_bit("pop5_led1", mole_leds[1], 1'b1);
        expect_bit("pop5_cnt", 1'b1, $countones(mole_leds) == 1);

        // Hit at idx 1, reload delay 2, then mole at idx 2.
        cyc(1, 0, 2, 4'b0010);
        expect_bit("hit1", hit_pulse, 1'b1);
        expect_bit("hit1_busy", busy, 1'b1);
        cyc(1, 1, 6, '0);
        cyc(1, 1, 6, '0);
        expect_bit("pop_idx2", mole_leds[2], 1'b1);

        // Hit on idx 2.
        cyc(1, 0, 6, 4'b0100);
        expect_bit("hit2", hit_pulse, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1, 1, 6, '0);
        expect_bit("pop_again", mole_leds[2], 1'b1);

        // Timeout on the 3rd tick.
        cyc(1, 1, 6, '0);
        cyc(1, 1, 6, '0);
        cyc(1, 1, 6, '0);
        expect_bit("miss", miss_pulse, 1'b1);
        expect_bit("miss_leds", 1'b1, mole_leds == '0);

        // Wait 6 ticks, mole at idx 0; wrong press, then hit on final tick.
        for (int i = 0; i < 6; i++) cyc(1, 1, 4, '0);
        expect_bit("pop_idx0", mole_leds[0], 1'b1);
        cyc(1, 0, 4, 4'b0010);
        expect_bit("wrong", wrong_pulse, 1'b1);
        expect_bit("wrong_stay", mole_leds[0], 1'b1);
        cyc(1, 1, 4, '0);
        cyc(1, 1, 4, '0);
        cyc(1, 1, 0, 4'b0001);
        expect_bit("hit_final", hit_pulse, 1'b1);
        expect_bit("no_miss", miss_pulse, 1'b0);

        // Delay word 0 means one tick.
        cyc(1, 1, 3, '0);
        expect_bit("zero_delay", mole_leds[3], 1'b1);

        // Hit, then drop enable during WAIT.
        cyc(1, 0, 7, 4'b1000);
        cyc(0, 1, 7, '0);
        expect_bit("disable_idle", busy, 1'b0);

        // Reach UP then reset mid-UP.
        cyc(1, 0, 1, '0);
        cyc(1, 1, 1, '0);
        expect_bit("pre_reset_up", mole_leds[1], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check();
        @(negedge clk);
        check();
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic en, tk;
            logic [NM-1:0] bt;
            int rv;
            en = ($urandom_range(0, 63) != 0);
            tk = ($urandom_range(0, 2) == 0);
            rv = $urandom_range(0, 9);
            bt = ($urandom_range(0, 5) == 0) ? NM'($urandom_range(1, 15)) : '0;
            cyc(en, tk, rv, bt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
